sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Composites up to N_SPRITES rectangular sprites over a background colour for the VGA pixel path.
//  Sits between the vga timing generator and the vga_r/g/b/hs/vs pins. Runs in the pixel clock domain.
//  Each sprite reads its own external image memory, typically a manta memory port.
//  Adds runtime positions, per-sprite enable, colour-key transparency, power-of-two scaling and
//  latency-matched sync/blank pipelining.
// PARAMETERS
//  N_SPRITES    2      number of sprite channels; index 0 has highest priority
//  WIDTH        128    sprite width in source pixels; power of two
//  HEIGHT       128    sprite height in source pixels
//  SCALE_LOG2   0      each source pixel drawn 2^SCALE_LOG2 x 2^SCALE_LOG2
//  MEM_LATENCY  2      cycles from mem_addr valid to mem_data valid; >=1
//  COLOR_W      12     pixel width, RGB444
//  KEY_COLOR    12'hF0F  source pixels equal to this are transparent
// PORTS
//  clk        in   1                  pixel clock, 65 MHz
//  rstn       in   1                  synchronous, active-low reset
//  hcount_in  in   11                 from vga generator
//  vcount_in  in   10                 from vga generator
//  hsync_in   in   1                  active-high, as produced by the generator
//  vsync_in   in   1                  active-high, as produced by the generator
//  blank_in   in   1                  active-high, as produced by the generator
//  pos_x      in   N_SPRITES*11       packed x of sprite top-left corner; sprite i is [i*11 +: 11]
//  pos_y      in   N_SPRITES*10       packed y of sprite top-left corner
//  pos_we     in   N_SPRITES          per-sprite strobe; writes pending position and enable
//  en_in      in   N_SPRITES          pending enable value, captured on pos_we
//  bg_color   in   COLOR_W            colour drawn where no opaque sprite pixel exists
//  mem_addr   out  N_SPRITES*$clog2(WIDTH*HEIGHT)  per-sprite image address
//  mem_data   in   N_SPRITES*COLOR_W  per-sprite pixel, MEM_LATENCY cycles after mem_addr
//  pixel_out  out  COLOR_W            composited colour; 0 while blanking
//  hsync_out  out  1                  hsync_in delayed by LAT cycles
//  vsync_out  out  1                  vsync_in delayed by LAT cycles
//  blank_out  out  1                  blank_in delayed by LAT cycles
// BEHAVIOUR
//  - Latency: LAT = MEM_LATENCY + 2. Stage 0 registers addresses and hit flags. Then MEM_LATENCY
//    cycles of memory delay. The final stage registers the composite and the delayed syncs.
//  - All syncs, blank and hit flags travel in a shift pipe of identical depth, so alignment is exact.
//  - Position registers are double-buffered. pos_we[i] loads pending[i] = {pos_x, pos_y, en_in}.
//  - Frame start is the cycle where hcount_in==0 && vcount_in==0. At frame start, active <= pending
//    for all sprites, so there is no tearing.
//  - Simultaneous pos_we and frame start: the old pending is applied. The new write lands in pending
//    and takes effect next frame.
//  - Hit test for sprite i: hcount in [x, x+(WIDTH<<S)) and vcount in [y, y+(HEIGHT<<S)).
//    All comparisons use 12-bit unsigned arithmetic, so a sprite partly off the right or bottom
//    edge clips and never wraps.
//  - Address: ((hcount-x)>>S) + ((vcount-y)>>S)*WIDTH. mem_addr is driven 0 when there is no hit.
//  - Composite: the lowest-index sprite with a hit, enable set and mem_data != KEY_COLOR wins.
//    Otherwise pixel_out = bg_color.
//  - When the delayed blank is 1, pixel_out is forced to 0.
//  - Reset (rstn==0 at a clk edge, including mid-frame):
//    - pending and active positions and enables clear to 0;
//    - the whole pipe flushes;
//    - pixel_out=0, hsync_out=0, vsync_out=0, blank_out=1, mem_addr=0.
//    Normal output resumes LAT cycles after release.
//  - No stalls and no backpressure: one pixel in and one pixel out every cycle.
// STRUCTURE
//  - Shared package vga_pkg: H_W=11, V_W=10, COLOR_W, typedef pixel_t (logic [11:0]) and
//    typedef sprite_pos_t (struct: x, y, en).
//  - One sub-module, sprite_channel, instantiated N_SPRITES times. It holds the pending/active
//    registers, the hit test, the address calculation and a hit-flag delay.
//  - The top holds the sync pipe and the priority mux.
// TESTING
//  1. Reset: hold rstn=0 for 5 cycles with blank_in=0 -> blank_out=1, pixel_out=0, hsync_out=0.
//     After release, first real pixel appears after 4 cycles (MEM_LATENCY=2).
//  2. Single sprite at (0,0) enabled, memory model returns the address as colour.
//     Pixel (5,3) -> pixel_out=12'h185, exactly 4 cycles after hcount_in=5, vcount_in=3.
//  3. Transparency: sprite0 returns KEY_COLOR 12'hF0F and sprite1 returns 12'h0A0 at overlap
//     -> 12'h0A0. Both return KEY_COLOR -> bg_color.
//  4. Priority: both sprites opaque at (10,10) -> sprite0 colour.
//     Disable sprite0 via pos_we -> still sprite0 until next frame start, then sprite1.
//  5. Clipping: pos_x=1000, WIDTH=128 -> hits only hcount 1000..1127.
//     hcount 0..127 shows bg_color (no wrap).
//  6. SCALE_LOG2=1: pixels (0,0), (1,0), (0,1), (1,1) all read address 0.
//     Pixel (2,0) reads address 1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA widths, pixel type and sprite position record
package vga_pkg;
  localparam int H_W = 11;
  localparam int V_W = 10;
  localparam int COLOR_W = 12;
  typedef logic [COLOR_W-1:0] pixel_t;
  typedef struct packed {
    logic [H_W-1:0] x;
    logic [V_W-1:0] y;
    logic           en;
  } sprite_pos_t;
endpackage

// File: rtl/sprite_channel.sv
// sprite_channel: one sprite's double-buffered position, hit test, image address and hit delay
//   clk, rstn          pixel clock, synchronous active-low reset
//   hcount_i, vcount_i current pixel from the timing generator
//   frame_start_i      pending -> active transfer strobe
//   we_i, pos_i        pending position/enable write
//   addr_o             registered image address, 0 when outside the sprite
//   hit_o              enabled hit, delayed to line up with the memory data
module sprite_channel import vga_pkg::*; #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 128,
  parameter int SCALE_LOG2  = 0,
  parameter int MEM_LATENCY = 2,
  localparam int AW         = $clog2(WIDTH*HEIGHT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [H_W-1:0]   hcount_i,
  input  logic [V_W-1:0]   vcount_i,
  input  logic             frame_start_i,
  input  logic             we_i,
  input  sprite_pos_t      pos_i,
  output logic [AW-1:0]    addr_o,
  output logic             hit_o
);
  sprite_pos_t pend_q, pend_d, act_q, act_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [MEM_LATENCY:0] hit_q, hit_d;
  logic [11:0] h, v, x, y, dx, dy;
  logic in_h, in_v;
  // 12-bit arithmetic keeps x+width from wrapping, so sprites clip at the right/bottom edge
  always_comb begin
    h = 12'(hcount_i);
    v = 12'(vcount_i);
    x = 12'(act_q.x);
    y = 12'(act_q.y);
    dx = h - x;
    dy = v - y;
    in_h = h >= x && h < x + 12'(WIDTH << SCALE_LOG2);
    in_v = v >= y && v < y + 12'(HEIGHT << SCALE_LOG2);
    pend_d = we_i ? pos_i : pend_q;
    act_d = frame_start_i ? pend_q : act_q;
    addr_d = (in_h && in_v) ? AW'(dx >> SCALE_LOG2) + AW'(dy >> SCALE_LOG2) * AW'(WIDTH) : '0;
    hit_d = {hit_q[MEM_LATENCY-1:0], in_h && in_v && act_q.en};
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      pend_q <= '0;
      act_q <= '0;
      addr_q <= '0;
      hit_q <= '0;
    end else begin
      pend_q <= pend_d;
      act_q <= act_d;
      addr_q <= addr_d;
      hit_q <= hit_d;
    end
  assign addr_o = addr_q;
  assign hit_o = hit_q[MEM_LATENCY];
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: composites N_SPRITES colour-keyed, scaled sprites over a background colour
//   clk, rstn                       pixel clock, synchronous active-low reset
//   hcount_in..blank_in             timing generator inputs
//   pos_x, pos_y, pos_we, en_in     per-sprite pending position/enable writes
//   bg_color                        colour where no opaque sprite pixel exists
//   mem_addr / mem_data             per-sprite image memory port
//   pixel_out, hsync_out, vsync_out, blank_out   outputs, MEM_LATENCY+2 cycles behind the inputs
module sprite_compositor import vga_pkg::*; #(
  parameter int N_SPRITES   = 2,
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 128,
  parameter int SCALE_LOG2  = 0,
  parameter int MEM_LATENCY = 2,
  parameter int COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F,
  localparam int AW         = $clog2(WIDTH*HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [H_W-1:0]               hcount_in,
  input  logic [V_W-1:0]               vcount_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         blank_in,
  input  logic [N_SPRITES*H_W-1:0]     pos_x,
  input  logic [N_SPRITES*V_W-1:0]     pos_y,
  input  logic [N_SPRITES-1:0]         pos_we,
  input  logic [N_SPRITES-1:0]         en_in,
  input  logic [COLOR_W-1:0]           bg_color,
  output logic [N_SPRITES*AW-1:0]      mem_addr,
  input  logic [N_SPRITES*COLOR_W-1:0] mem_data,
  output logic [COLOR_W-1:0]           pixel_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic                         blank_out
);
  logic frame_start;
  logic [N_SPRITES-1:0] hit;
  // {hsync, vsync, blank} per stage, same depth as the channels' hit pipes
  logic [MEM_LATENCY:0][2:0] sync_q, sync_d;
  logic [2:0] out_q;
  logic [COLOR_W-1:0] pix_q, pix_d, col;
  assign frame_start = hcount_in == '0 && vcount_in == '0;
  for (genvar i = 0; i < N_SPRITES; i++) begin : g_ch
    sprite_pos_t pos;
    assign pos = '{x: pos_x[i*H_W +: H_W], y: pos_y[i*V_W +: V_W], en: en_in[i]};
    sprite_channel #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCALE_LOG2(SCALE_LOG2), .MEM_LATENCY(MEM_LATENCY)
    ) u_ch (
      .clk(clk), .rstn(rstn), .hcount_i(hcount_in), .vcount_i(vcount_in),
      .frame_start_i(frame_start), .we_i(pos_we[i]), .pos_i(pos),
      .addr_o(mem_addr[i*AW +: AW]), .hit_o(hit[i])
    );
  end
  // walk from the highest index down so the lowest-index opaque sprite wins
  always_comb begin
    col = bg_color;
    for (int i = N_SPRITES-1; i >= 0; i--)
      if (hit[i] && mem_data[i*COLOR_W +: COLOR_W] != KEY_COLOR) col = mem_data[i*COLOR_W +: COLOR_W];
    pix_d = sync_q[MEM_LATENCY][0] ? '0 : col;
    sync_d = {sync_q[MEM_LATENCY-1:0], hsync_in, vsync_in, blank_in};
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      sync_q <= {(MEM_LATENCY+1){3'b001}};
      out_q <= 3'b001;
      pix_q <= '0;
    end else begin
      sync_q <= sync_d;
      out_q <= sync_q[MEM_LATENCY];
      pix_q <= pix_d;
    end
  assign pixel_out = pix_q;
  assign {hsync_out, vsync_out, blank_out} = out_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed vectors with a due-cycle scoreboard for two compositors (scale 1x and 2x)
module tb_sprite_compositor;
  localparam int N = 2, AW = 14, LAT = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0] vcount_in = '0;
  logic hsync_in = 1'b1, vsync_in = 1'b0, blank_in = 1'b0;
  logic [N*11-1:0] pos_x = '0;
  logic [N*10-1:0] pos_y = '0;
  logic [N-1:0] pos_we = '0, en_in = '0, nxt_we = '0;
  logic [11:0] bg_color = 12'h123;
  logic [N*AW-1:0] mem_addr0, mem_addr1;
  logic [N*12-1:0] mem_data0, mem_data1, d0_q, d1_q;
  logic [11:0] pix0, pix1;
  logic hs0, vs0, bl0, hs1, vs1, bl1;
  logic [N-1:0] mode = '0;
  logic [N*12-1:0] cval = '0;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    int          due;
    string       tag;
    logic [11:0] p0, p1;
    logic        c1;
    logic [2:0]  s;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_compositor u_dut (
    .clk(clk), .rstn(rstn), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we), .en_in(en_in), .bg_color(bg_color),
    .mem_addr(mem_addr0), .mem_data(mem_data0),
    .pixel_out(pix0), .hsync_out(hs0), .vsync_out(vs0), .blank_out(bl0)
  );
  sprite_compositor #(.SCALE_LOG2(1)) u_dut_s (
    .clk(clk), .rstn(rstn), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we), .en_in(en_in), .bg_color(bg_color),
    .mem_addr(mem_addr1), .mem_data(mem_data1),
    .pixel_out(pix1), .hsync_out(hs1), .vsync_out(vs1), .blank_out(bl1)
  );

  // image memory: mode 0 returns the address as colour, mode 1 a constant; two-cycle latency
  function automatic logic [11:0] rd(int i, logic [AW-1:0] a);
    return mode[i] ? cval[i*12 +: 12] : a[11:0];
  endfunction
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      d0_q[i*12 +: 12] <= rd(i, mem_addr0[i*AW +: AW]);
      d1_q[i*12 +: 12] <= rd(i, mem_addr1[i*AW +: AW]);
    end
    mem_data0 <= d0_q;
    mem_data1 <= d1_q;
  end

  task automatic chk(string tag, logic [14:0] act, logic [14:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h required %h", tag, cyc, act, req);
    end
  endtask

  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin : pop
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) chk({e.tag, "_late"}, 15'(cyc), 15'(e.due));
      chk(e.tag, {pix0, hs0, vs0, bl0}, {e.p0, e.s});
      if (e.c1) chk({e.tag, "_x2"}, 15'(pix1), 15'(e.p1));
    end

  task automatic push(string tag, int due, logic [11:0] p0, logic [2:0] s, logic c1 = 1'b0, logic [11:0] p1 = '0);
    exp_t e;
    e.due = due; e.tag = tag; e.p0 = p0; e.p1 = p1; e.c1 = c1; e.s = s;
    q.push_back(e);
  endtask

  task automatic px(string tag, int h, int v, logic hs, logic vs, logic bl, logic [11:0] e0,
                    logic c1 = 1'b0, logic [11:0] e1 = '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    hcount_in = 11'(h); vcount_in = 10'(v);
    hsync_in = hs; vsync_in = vs; blank_in = bl;
    pos_we = nxt_we; nxt_we = '0;
    push(tag, cyc + LAT, bl ? 12'h000 : e0, {hs, vs, bl}, c1, bl ? 12'h000 : e1);
  endtask

  task automatic idle(); px("idle", 1500, 700, 1'b0, 1'b0, 1'b1, 12'h000); endtask
  task automatic fs(); px("fs", 0, 0, 1'b0, 1'b1, 1'b1, 12'h000); endtask
  task automatic flush(); repeat (4) idle(); endtask

  task automatic set_pos(int i, int x, int y, logic en);
    pos_x[i*11 +: 11] = 11'(x);
    pos_y[i*10 +: 10] = 10'(y);
    en_in[i] = en;
    nxt_we[i] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      push("reset", cyc, 12'h000, 3'b001);
    end
    for (int k = 1; k <= LAT; k++) push("flush", cyc + k, 12'h000, 3'b001);
    px("release", 1, 0, 1'b1, 1'b0, 1'b0, 12'h123);
    // single sprite at (0,0), colour = address
    set_pos(0, 0, 0, 1'b1); idle(); fs();
    px("t2_5_3", 5, 3, 1'b0, 1'b0, 1'b0, 12'h185);
    px("t2_127_127", 127, 127, 1'b0, 1'b0, 1'b0, 12'hFFF);
    px("t2_128_3", 128, 3, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t2_3_128", 3, 128, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t2_blank", 5, 3, 1'b0, 1'b0, 1'b1, 12'h000);
    px("t2_hsync", 2, 1, 1'b1, 1'b0, 1'b0, 12'h082);
    // transparency
    flush(); mode = 2'b11; cval = {12'h0A0, 12'hF0F};
    set_pos(1, 0, 0, 1'b1); idle(); fs();
    px("t3_key0", 10, 10, 1'b0, 1'b0, 1'b0, 12'h0A0);
    flush(); cval = {12'hF0F, 12'hF0F};
    px("t3_bothkey", 10, 10, 1'b0, 1'b0, 1'b0, 12'h123);
    // priority and double buffering
    flush(); cval = {12'h222, 12'h111};
    set_pos(0, 10, 10, 1'b1); set_pos(1, 10, 10, 1'b1); idle(); fs();
    px("t4_pri", 10, 10, 1'b0, 1'b0, 1'b0, 12'h111);
    px("t4_left", 9, 10, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t4_corner", 137, 137, 1'b0, 1'b0, 1'b0, 12'h111);
    px("t4_past", 138, 10, 1'b0, 1'b0, 1'b0, 12'h123);
    set_pos(0, 10, 10, 1'b0); idle();
    px("t4_pending", 10, 10, 1'b0, 1'b0, 1'b0, 12'h111);
    fs();
    px("t4_switched", 10, 10, 1'b0, 1'b0, 1'b0, 12'h222);
    set_pos(1, 10, 10, 1'b0); fs();
    px("t4_we_at_fs", 10, 10, 1'b0, 1'b0, 1'b0, 12'h222);
    fs();
    px("t4_next_frame", 10, 10, 1'b0, 1'b0, 1'b0, 12'h123);
    // clipping without wrap
    flush(); mode = 2'b00;
    set_pos(0, 1000, 0, 1'b1); idle(); fs();
    px("t5_first", 1001, 1, 1'b0, 1'b0, 1'b0, 12'h081);
    px("t5_last", 1127, 0, 1'b0, 1'b0, 1'b0, 12'h07F);
    px("t5_past", 1128, 0, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t5_before", 999, 0, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t5_nowrap", 5, 0, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t5_nowrap2", 127, 1, 1'b0, 1'b0, 1'b0, 12'h123);
    set_pos(0, 1990, 1000, 1'b1); idle(); fs();
    px("t5_right", 2000, 1000, 1'b0, 1'b0, 1'b0, 12'h00A);
    px("t5_botright", 2047, 1023, 1'b0, 1'b0, 1'b0, 12'hBB9);
    px("t5_wrap_x", 5, 1000, 1'b0, 1'b0, 1'b0, 12'h123);
    px("t5_wrap_y", 2000, 5, 1'b0, 1'b0, 1'b0, 12'h123);
    // 2x scaling on the second compositor
    flush();
    set_pos(0, 0, 0, 1'b1); idle(); fs();
    px("t6_0_0", 0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h000);
    px("t6_1_0", 1, 0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 12'h000);
    px("t6_0_1", 0, 1, 1'b0, 1'b0, 1'b0, 12'h080, 1'b1, 12'h000);
    px("t6_1_1", 1, 1, 1'b0, 1'b0, 1'b0, 12'h081, 1'b1, 12'h000);
    px("t6_2_0", 2, 0, 1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 12'h001);
    px("t6_3_1", 3, 1, 1'b0, 1'b0, 1'b0, 12'h083, 1'b1, 12'h001);
    px("t6_0_2", 0, 2, 1'b0, 1'b0, 1'b0, 12'h100, 1'b1, 12'h080);
    px("t6_130_3", 130, 3, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 12'h0C1);
    px("t6_255_255", 255, 255, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 12'hFFF);
    px("t6_256_0", 256, 0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 12'h123);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
